// File: rtl/bcd_pkg.sv
// Shared BCD definitions: conversion sizes, converter FSM states
// and the 4-bit BCD digit type used by binary<->BCD stages.
package bcd_pkg;

  localparam int BIN_W      = 16;
  localparam int NUM_DIGITS = 5;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 when the digit is >= 5.
// Ports: din (4-bit digit in), dout (4-bit corrected digit out).
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit/cycle).
// Ports: clk, rst (sync, active-high), start, bin -> busy, done, a5..a1.
module bin2bcd_seq #(
  parameter int BIN_W      = bcd_pkg::BIN_W,
  parameter int NUM_DIGITS = bcd_pkg::NUM_DIGITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [3:0]       a5,
  output logic [3:0]       a4,
  output logic [3:0]       a3,
  output logic [3:0]       a2,
  output logic [3:0]       a1
);

  import bcd_pkg::*;

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BCD_W-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [BCD_W-1:0]       bcd_adj;
  logic [BCD_W+BIN_W-1:0] cat_sh;
  bcd_digit_t             dig [NUM_DIGITS];

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    bcd_add3 u_add3 (
      .din  (bcd_q[4*i +: 4]),
      .dout (bcd_adj[4*i +: 4])
    );
    assign dig[i] = res_q[4*i +: 4];
  end

  // Corrected digits and remaining binary shift as one word.
  assign cat_sh = {bcd_adj, bin_q} << 1;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = bin;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = cat_sh[BIN_W +: BCD_W];
        bin_d = cat_sh[BIN_W-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          // Last iteration: publish the finished digits directly.
          res_d   = cat_sh[BIN_W +: BCD_W];
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  assign a1 = dig[0];
  assign a2 = dig[1];
  assign a3 = dig[2];
  assign a4 = dig[3];
  assign a5 = dig[4];

endmodule
